// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply on {P,MPLR}
// or restoring divide on {REM,QUO}. Purely combinational.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Partial remainder shifted left by one, pulling in the next dividend bit.
        trial   = acc[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, operand};
        if (is_div) begin
            if (diff[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers. Operates on
// magnitudes for WIDTH steps, then applies the signed fix-up in a single cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_wrt_en,
    input  logic             lo_wrt_en,
    input  logic [WIDTH-1:0] wrt_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               start_div;
    logic               start_sa, start_sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc_q),
        .operand (operand_q),
        .is_div  (is_div_q),
        .acc_next(acc_step)
    );

    always_comb begin
        start_div = op_is_div(op);
        start_sa  = op_is_signed(op) & src_a[WIDTH-1];
        start_sb  = op_is_signed(op) & src_b[WIDTH-1];
        mag_a     = start_sa ? -src_a : src_a;
        mag_b     = start_sb ? -src_b : src_b;
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        // On divide-by-zero the quotient is all ones and the remainder is |a|;
        // restoring the dividend sign recovers the original src_a bit pattern.
        rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        quo_fix   = ((sign_a_q ^ sign_b_q) && !div_zero_q) ? -acc_q[WIDTH-1:0]
                                                            : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        operand_d  = operand_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hi_wrt_en) hi_d = wrt_data;
                if (lo_wrt_en) lo_d = wrt_data;
                if (start) begin
                    is_div_d   = start_div;
                    sign_a_d   = start_sa;
                    sign_b_d   = start_sb;
                    operand_d  = start_div ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
                    cnt_d      = '0;
                    div_zero_d = start_div && (src_b == '0);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            operand_q  <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            operand_q  <= operand_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
